// File: rtl/vga_sprite_mover.sv
// vga_sprite_mover: button-driven rectangular sprite with hold-to-accelerate motion and registered render
// Ports: clk pixel clock; rst_n async active-low reset; btn_left/right/up/down raw buttons;
//   frame_start one-cycle vblank pulse; video_active display enable; pix_x/pix_y beam position;
//   pos_x/pos_y live sprite corner; pix_rgb/sprite_hit render outputs (1-cycle latency); fast_mode in FAST.
// Optional: define SPRITE_WRAP_EN to wrap at screen limits instead of clamping.
module vga_sprite_mover #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPRITE_W = 50,
  parameter int SPRITE_H = 35,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 200,
  parameter int STEP_TICKS = 234375,
  parameter int FAST_AFTER = 16,
  parameter logic [5:0] COLOR = 6'b000011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       frame_start,
  input  logic       video_active,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [5:0] pix_rgb,
  output logic       sprite_hit,
  output logic       fast_mode
);
  localparam int MAXX = SCREEN_W - SPRITE_W;
  localparam int MAXY = SCREEN_H - SPRITE_H;
  localparam int TW = STEP_TICKS > 1 ? $clog2(STEP_TICKS) : 1;
  localparam int SW = $clog2(FAST_AFTER + 1);
  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
  state_t state_q, state_d;
  logic [3:0] sync1_q, sync1_d, sync2_q, dir_q, dir_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] step_q, step_d;
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d, disp_x_q, disp_x_d, disp_y_q, disp_y_d;
  logic [5:0] rgb_q, rgb_d;
  logic hit_q, hit_d, fast_q, fast_d, do_step, in_x, in_y;
  logic [1:0] amt;
  // Signed 11-bit sum exposes underflow below 0 before the limit decision.
  function automatic logic [9:0] axis(input logic [9:0] p, input logic inc, input logic dec,
                                      input logic [1:0] a, input int mx);
    logic signed [10:0] n;
    n = $signed({1'b0, p}) + (inc ? $signed({9'd0, a}) : dec ? -$signed({9'd0, a}) : 11'sd0);
`ifdef SPRITE_WRAP_EN
    axis = n < 0 ? 10'(mx) : n > mx ? 10'd0 : n[9:0];
`else
    axis = n < 0 ? 10'd0 : n > mx ? 10'(mx) : n[9:0];
`endif
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Direction vector {x+, x-, y+, y-}; opposite buttons cancel on their axis.
  always_comb begin
    sync1_d = {btn_left, btn_right, btn_up, btn_down};
    dir_d = {sync2_q[2] & ~sync2_q[3], sync2_q[3] & ~sync2_q[2],
             sync2_q[0] & ~sync2_q[1], sync2_q[1] & ~sync2_q[0]};
  end
  // A direction change restarts acceleration; otherwise the tick counter paces the steps.
  always_comb begin
    state_d = state_q;
    tick_d = '0;
    step_d = step_q;
    do_step = 1'b0;
    if (dir_d == 4'd0) begin
      state_d = IDLE;
      step_d = '0;
    end else if (state_q == IDLE || dir_d != dir_q) begin
      state_d = SLOW;
      step_d = '0;
    end else if (tick_q == TW'(STEP_TICKS - 1)) begin
      do_step = 1'b1;
      step_d = step_q == SW'(FAST_AFTER) ? step_q : step_q + 1'b1;
      state_d = step_d == SW'(FAST_AFTER) ? FAST : state_q;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end
  // The draw latch samples the pre-step position so a frame never shows a half-applied move.
  always_comb begin
    amt = state_q == FAST ? 2'd2 : 2'd1;
    pos_x_d = do_step ? axis(pos_x_q, dir_d[3], dir_d[2], amt, MAXX) : pos_x_q;
    pos_y_d = do_step ? axis(pos_y_q, dir_d[1], dir_d[0], amt, MAXY) : pos_y_q;
    disp_x_d = frame_start ? pos_x_q : disp_x_q;
    disp_y_d = frame_start ? pos_y_q : disp_y_q;
    in_x = {1'b0, pix_x} >= {1'b0, disp_x_q} && {1'b0, pix_x} < {1'b0, disp_x_q} + 11'(SPRITE_W);
    in_y = {1'b0, pix_y} >= {1'b0, disp_y_q} && {1'b0, pix_y} < {1'b0, disp_y_q} + 11'(SPRITE_H);
    hit_d = video_active & in_x & in_y;
    rgb_d = hit_d ? COLOR : 6'd0;
    fast_d = state_d == FAST;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dir_q <= '0;
      tick_q <= '0;
      step_q <= '0;
      pos_x_q <= 10'(INIT_X);
      pos_y_q <= 10'(INIT_Y);
      disp_x_q <= 10'(INIT_X);
      disp_y_q <= 10'(INIT_Y);
      rgb_q <= '0;
      hit_q <= 1'b0;
      fast_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync1_q;
      dir_q <= dir_d;
      tick_q <= tick_d;
      step_q <= step_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      disp_x_q <= disp_x_d;
      disp_y_q <= disp_y_d;
      rgb_q <= rgb_d;
      hit_q <= hit_d;
      fast_q <= fast_d;
    end
  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign pix_rgb = rgb_q;
  assign sprite_hit = hit_q;
  assign fast_mode = fast_q;
endmodule
